// File: rtl/seg_pkg.sv
// Seven-segment encoding shared by the display encoder and the scan decoder.
// Patterns are active-low, with bits 6..0 = g..a.
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_NONE   = 4'b1111;

    // Entry n is the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
        SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        CAPTURED
    } scan_state_e;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } pins_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational reverse lookup from a segment pattern to a hex nibble.
// Also flags the all-off pattern.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        valid  = 1'b0;
        nibble = 4'h0;
        blank  = (pattern == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_TABLE[i[3:0]]) begin
                valid  = 1'b1;
                nibble = i[3:0];
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the four displayed digits from multiplexed active-low seg/an pins.
// Each stable scan window is captured exactly once.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic [3:0]  digit_err,
    output logic        frame_valid
);

    localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

    pins_t       sync1, s, s_prev;
    scan_state_e state;
    logic [7:0]  cnt, cnt_inc;
    logic [3:0]  seen, seen_next, cap_mask;
    logic        capture;
    logic        dec_valid, dec_blank;
    logic [3:0]  dec_nib;

    // Idle pins read as all-ones, so reset to that rather than zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '1;
            s      <= '1;
            s_prev <= '1;
        end else begin
            sync1  <= {an_in, seg_in};
            s      <= sync1;
            s_prev <= s;
        end
    end

    assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign capture  = (state == SETTLING) && (s.an != AN_NONE) &&
                      (s == s_prev) && (cnt_inc == SETTLE);
    assign cap_mask = capture ? ~s.an : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else if (s.an == AN_NONE) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    state <= SETTLING;
                    cnt   <= 8'd0;
                end
                SETTLING: begin
                    if (s != s_prev) begin
                        cnt <= 8'd0;
                    end else begin
                        cnt <= cnt_inc;
                        if (capture) state <= CAPTURED;
                    end
                end
                CAPTURED: begin
                    if (s != s_prev) begin
                        state <= SETTLING;
                        cnt   <= 8'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // One decoder serves all selected digits: they all see the same seg value.
    seg_pattern_decode u_dec (
        .pattern (s.seg[6:0]),
        .valid   (dec_valid),
        .blank   (dec_blank),
        .nibble  (dec_nib)
    );

    assign seen_next = seen | cap_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= 16'h0000;
            dp          <= 4'b0000;
            blank       <= 4'b1111;
            digit_err   <= 4'b0000;
            frame_valid <= 1'b0;
            seen        <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cap_mask[i]) begin
                    dp[i] <= ~s.seg[7];
                    if (dec_valid) begin
                        digits[i*4 +: 4] <= dec_nib;
                        blank[i]         <= 1'b0;
                        digit_err[i]     <= 1'b0;
                    end else if (dec_blank) begin
                        blank[i]     <= 1'b1;
                        digit_err[i] <= 1'b0;
                    end else begin
                        blank[i]     <= 1'b0;
                        digit_err[i] <= 1'b1;
                    end
                end
            end
            if (seen_next == 4'b1111) begin
                frame_valid <= 1'b1;
                seen        <= 4'b0000;
            end else begin
                frame_valid <= 1'b0;
                seen        <= seen_next;
            end
        end
    end

endmodule
